// File: rtl/tone_detector.sv
// Square-wave tone detector: measures each half-period of tone_in in clocks,
// classifies it as the low or high note and locks after a run of agreeing measurements.
module tone_detector #(
  parameter int CNT_W      = 16,
  parameter int LO_HALF    = 28409,
  parameter int HI_HALF    = 20409,
  parameter int TOL        = 64,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             note_lo,
  output logic             note_hi,
  output logic             locked,
  output logic             timeout
);

  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int LO_MIN_I = (LO_HALF > TOL) ? LO_HALF - TOL : 0;
  localparam int LO_MAX_I = (LO_HALF + TOL > CNT_MAX) ? CNT_MAX : LO_HALF + TOL;
  localparam int HI_MIN_I = (HI_HALF > TOL) ? HI_HALF - TOL : 0;
  localparam int HI_MAX_I = (HI_HALF + TOL > CNT_MAX) ? CNT_MAX : HI_HALF + TOL;

  localparam logic [CNT_W-1:0] LO_MIN = CNT_W'(LO_MIN_I);
  localparam logic [CNT_W-1:0] LO_MAX = CNT_W'(LO_MAX_I);
  localparam logic [CNT_W-1:0] HI_MIN = CNT_W'(HI_MIN_I);
  localparam logic [CNT_W-1:0] HI_MAX = CNT_W'(HI_MAX_I);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_LO, CLS_HI} class_t;

  state_t           state;
  class_t           cls, last_cls;
  logic             s1, s2, s3;
  logic             tone_edge;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       streak, streak_next;

  assign tone_edge = s2 ^ s3;

  // Windows are checked in priority order so LO wins if they were ever configured to overlap.
  always_comb begin
    cls = CLS_NONE;
    if (cnt >= LO_MIN && cnt <= LO_MAX)
      cls = CLS_LO;
    else if (cnt >= HI_MIN && cnt <= HI_MAX)
      cls = CLS_HI;
  end

  always_comb begin
    streak_next = 4'd0;
    if (cls != CLS_NONE) begin
      if (cls != last_cls)
        streak_next = 4'd1;
      else if (streak >= LOCK_N)
        streak_next = LOCK_N;
      else
        streak_next = streak + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      streak       <= 4'd0;
      last_cls     <= CLS_NONE;
      state        <= IDLE;
      half_period  <= '0;
      period_valid <= 1'b0;
      note_lo      <= 1'b0;
      note_hi      <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      s1           <= tone_in;
      s2           <= s1;
      s3           <= s2;
      period_valid <= 1'b0;
      timeout      <= 1'b0;

      if (tone_edge)
        cnt <= CNT_W'(1);
      else if (cnt != TMO)
        cnt <= cnt + CNT_W'(1);

      if (tone_edge) begin
        if (state == IDLE) begin
          // First edge only establishes a reference point; nothing is measured yet.
          state    <= MEASURE;
          streak   <= 4'd0;
          last_cls <= CLS_NONE;
        end else begin
          half_period  <= cnt;
          period_valid <= 1'b1;
          streak       <= streak_next;
          last_cls     <= cls;
          if (state == LOCKED && cls == last_cls) begin
            state <= LOCKED;
          end else if (state == MEASURE && streak_next == LOCK_N) begin
            state   <= LOCKED;
            note_lo <= (cls == CLS_LO);
            note_hi <= (cls == CLS_HI);
            locked  <= 1'b1;
          end else begin
            state   <= MEASURE;
            note_lo <= 1'b0;
            note_hi <= 1'b0;
            locked  <= 1'b0;
          end
        end
      end else if (state != IDLE && cnt == TMO) begin
        timeout <= 1'b1;
        note_lo <= 1'b0;
        note_hi <= 1'b0;
        locked  <= 1'b0;
        streak  <= 4'd0;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector, run with scaled-down note periods so the
// whole sequence (including a full timeout) fits in a short simulation.
module tb_tone_detector;

  localparam int CNT_W      = 10;
  localparam int LO_HALF    = 284;
  localparam int HI_HALF    = 204;
  localparam int TOL        = 8;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 1023;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             period_valid, note_lo, note_hi, locked, timeout;

  typedef struct {
    int half;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   tmo_count = 0;

  int m_idle = 1;
  int m_run = 0;
  int m_cls = 0;
  int m_lock = 0;

  tone_detector #(
    .CNT_W(CNT_W), .LO_HALF(LO_HALF), .HI_HALF(HI_HALF),
    .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tone_in(tone_in),
    .half_period(half_period),
    .period_valid(period_valid),
    .note_lo(note_lo),
    .note_hi(note_hi),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int classify(input int h);
    if (h >= LO_HALF - TOL && h <= LO_HALF + TOL) return 1;
    if (h >= HI_HALF - TOL && h <= HI_HALF + TOL) return 2;
    return 0;
  endfunction

  // Wait h clocks, toggle the tone, and predict what the detector reports for that interval.
  task automatic applyStimulus(input int h);
    int   c;
    exp_t e;
    repeat (h) @(negedge clk);
    tone_in = ~tone_in;
    if (m_idle != 0) begin
      m_idle = 0;
      return;
    end
    c = classify(h);
    if (c == 0)
      m_run = 0;
    else if (c == m_cls)
      m_run = (m_run + 1 > LOCK_COUNT) ? LOCK_COUNT : m_run + 1;
    else
      m_run = 1;
    m_cls = c;
    if (m_lock != 0 && c != m_lock) m_lock = 0;
    if (m_lock == 0 && m_run == LOCK_COUNT) m_lock = c;
    e.half = h;
    e.lo   = (m_lock == 1) ? 1 : 0;
    e.hi   = (m_lock == 2) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic modelIdle();
    m_idle = 1;
    m_run  = 0;
    m_cls  = 0;
    m_lock = 0;
  endtask

  task automatic resetDut(input int n);
    @(negedge clk);
    rst     = 1'b1;
    tone_in = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    modelIdle();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_half_period"}, int'(half_period), 0);
    checkOutput({tag, "_period_valid"}, int'(period_valid), 0);
    checkOutput({tag, "_note_lo"}, int'(note_lo), 0);
    checkOutput({tag, "_note_hi"}, int'(note_hi), 0);
    checkOutput({tag, "_locked"}, int'(locked), 0);
    checkOutput({tag, "_timeout"}, int'(timeout), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (timeout) tmo_count++;
      if (period_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("half_period", int'(half_period), e.half);
          checkOutput("note_lo", int'(note_lo), e.lo);
          checkOutput("note_hi", int'(note_hi), e.hi);
          checkOutput("locked", int'(locked), e.lo | e.hi);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut(2);
    checkAllZero("reset");

    // Low-note lock: 6 toggles, lock on the 5th.
    for (int i = 0; i < 6; i++) applyStimulus(LO_HALF);

    // Switch to the high note.
    for (int i = 0; i < 5; i++) applyStimulus(HI_HALF);

    // Tolerance edges count, one clock beyond does not.
    applyStimulus(LO_HALF + TOL);
    applyStimulus(LO_HALF - TOL);
    applyStimulus(LO_HALF + TOL);
    applyStimulus(LO_HALF - TOL);
    applyStimulus(LO_HALF + TOL + 1);
    applyStimulus(HI_HALF + TOL);
    applyStimulus(HI_HALF - TOL);
    applyStimulus(LO_HALF - TOL - 1);

    // Glitch in a locked low-note wave.
    for (int i = 0; i < 4; i++) applyStimulus(LO_HALF);
    applyStimulus(100);
    applyStimulus(5);
    applyStimulus(LO_HALF - 105);
    for (int i = 0; i < 4; i++) applyStimulus(LO_HALF);

    // Timeout after a high-note lock.
    for (int i = 0; i < 4; i++) applyStimulus(HI_HALF);
    checkOutput("tmo_before_hold", tmo_count, 0);
    repeat (1200) @(negedge clk);
    checkOutput("tmo_pulses", tmo_count, 1);
    checkOutput("tmo_note_lo", int'(note_lo), 0);
    checkOutput("tmo_note_hi", int'(note_hi), 0);
    checkOutput("tmo_locked", int'(locked), 0);
    modelIdle();
    applyStimulus(300);
    applyStimulus(HI_HALF);

    // Reset while locked on the high note.
    for (int i = 0; i < 3; i++) applyStimulus(HI_HALF);
    repeat (10) @(negedge clk);
    checkOutput("prereset_note_hi", int'(note_hi), 1);
    checkOutput("prereset_locked", int'(locked), 1);
    resetDut(1);
    checkAllZero("midreset");
    applyStimulus(150);
    applyStimulus(LO_HALF);
    applyStimulus(LO_HALF);
    repeat (20) @(negedge clk);

    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("tmo_total", tmo_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
Receive-side counterpart of the square-wave tone generator. It takes a 1-bit square wave (a speaker line or a comparator output), synchronises it to clk and measures each half-period in clock cycles. It classifies the tone as the low note (half-period 28409 clocks) or the high note (20409 clocks) and asserts a lock once enough consecutive measurements agree. It sits between an external tone input and the switch/LED status logic.

Parameters:
CNT_W, 16, width of the half-period counter and of half_period
LO_HALF, 28409, target half-period of the low note, in clocks
HI_HALF, 20409, target half-period of the high note, in clocks
TOL, 64, allowed absolute deviation from a target, inclusive
LOCK_COUNT, 4, consecutive same-class measurements needed to lock (1..15)
TIMEOUT, 65535, cycles without an edge before dropping to IDLE (must be at most 2^CNT_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
tone_in  input  1  asynchronous square-wave input
half_period  output  CNT_W  last measured half-period in clocks
period_valid  output  1  one-cycle pulse when half_period updates
note_lo  output  1  locked on the low note
note_hi  output  1  locked on the high note
locked  output  1  note_lo OR note_hi
timeout  output  1  one-cycle pulse when TIMEOUT expires

Behaviour:
- Reset: one clock, synchronous, active-high. While rst is high at a rising edge, all outputs and internal state clear on that edge: half_period=0, period_valid=0, note_lo=0, note_hi=0, locked=0, timeout=0, sync flops=0, cnt=0, streak=0, last class=NONE, state=IDLE. Reset mid-operation aborts any measurement; the next edge is treated as a first edge.
- Input conditioning: two-flop synchroniser s1->s2, then a delay flop s3.
  - edge = s2 XOR s3.
  - The edge is seen 3 clocks after tone_in changes. A constant latency does not bias the measured period.
- Counter cnt (CNT_W bits):
  - On an edge cycle: cnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at TIMEOUT.
  - So a wave toggling every H clocks gives cnt==H on the edge cycle.
- Classification, evaluated on the edge cycle using cnt:
  - LO if |cnt-LO_HALF|<=TOL.
  - HI if |cnt-HI_HALF|<=TOL.
  - Otherwise NONE. Windows must not overlap; LO takes priority if they do.
  - Use unsigned compares against precomputed bounds, not signed subtraction.
- States:
  - IDLE: no reference edge yet. The first edge moves to MEASURE. It produces no period_valid and no classification.
  - MEASURE: every edge registers half_period<=cnt and pulses period_valid on the next cycle.
    - Same class as last and not NONE: streak<=streak+1, saturating at LOCK_COUNT.
    - Otherwise: streak<=1 if class is not NONE, else 0.
    - Last class <= class.
    - When the updated streak equals LOCK_COUNT: go to LOCKED, and raise note_lo or note_hi in the same cycle as period_valid.
  - LOCKED: every edge still updates half_period and period_valid.
    - A class equal to the locked class keeps the lock.
    - Any other class: drop note_lo/note_hi/locked in the period_valid cycle and return to MEASURE. Streak becomes 1 for the new class (0 for NONE).
    - A switch between notes therefore needs LOCK_COUNT fresh matches before the other output rises.
  - Any state except IDLE: if cnt reaches TIMEOUT with no edge, pulse timeout for one cycle, clear note outputs, locked and streak, and go to IDLE. cnt holds at TIMEOUT until the next edge. The timeout pulse is not repeated while the wave stays idle.
- Outputs are registered. note_lo and note_hi are never high together. locked is always their OR.
- Edge cycle and TIMEOUT on the same cycle: the edge wins, no timeout pulse.

Test Plan:
- Low-note lock: rst for 2 clocks, then drive tone_in with half-period 28409 for 6 toggles. Expect period_valid pulses with half_period=28409 on toggles 2-6. note_lo and locked rise on the toggle-5 valid pulse. note_hi stays 0.
- Note switch: after the low lock, change the half-period to 20409. Expect note_lo to drop on the first 20409 measurement. note_hi rises on the 4th consecutive 20409 measurement.
- Tolerance bounds: half-periods 28473 (+64) and 28345 (-64) count toward the lock. Half-period 28474 gives class NONE, resets the streak to 0 and clears any lock.
- Timeout: lock on the high note, then hold tone_in constant. Expect a single timeout pulse when cnt reaches 65535, all note outputs 0, and state IDLE. The next toggle yields no period_valid; the toggle after that yields one.
- Reset mid-lock: assert rst for 1 clock while note_hi=1. The next cycle shows all outputs 0, and the first subsequent toggle produces no period_valid.
- Glitch: insert a 5-clock pulse into a locked 28409 wave. Expect period_valid with half_period≈5, class NONE, and the lock cleared. The lock returns after 4 clean measurements.
